bellek_hakemi: RTL and testbench

Two-way arbiter that shares the core's single main-memory port between the instruction-fetch path (buyruk, GETIR side) and the data path (veri, YURUT/load-store side). It grants one outstanding transaction at a time with round-robin fairness, presents registered request signals to memory, and returns read data with a one-cycle valid pulse. A timeout counter aborts transactions that memory never acknowledges. The pipeline control unit uses `mesgul_o` and the per-port valid pulses to drive its stall signals.

---
 rtl/bellek_hakemi_if.sv | 58 +++++
 rtl/bellek_hakemi.sv | 183 ++++++++++++++++++
 tb/tb_bellek_hakemi.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/bellek_hakemi_if.sv
// bellek_hakemi_if
// Groups the signals of the memory arbiter. It carries the instruction
// request port (bb_*), the data request port (vb_*), the status outputs and
// the main-memory port (bellek_*).
//   slave  : the arbiter's view. It takes requests and memory replies, and
//            drives read data, valid pulses, status and the memory request.
//   master : the surrounding core + memory view (the mirror image).
interface bellek_hakemi_if #(
   parameter int ADRES_BIT = 32,
   parameter int VERI_BIT  = 32
);
   localparam int MASKE_BIT = VERI_BIT / 8;

   // instruction port
   logic                 bb_istek_i;
   logic [ADRES_BIT-1:0] bb_adres_i;
   logic [VERI_BIT-1:0]  bb_veri_o;
   logic                 bb_gecerli_o;
   // data port
   logic                 vb_istek_i;
   logic                 vb_yaz_i;
   logic [ADRES_BIT-1:0] vb_adres_i;
   logic [VERI_BIT-1:0]  vb_veri_i;
   logic [MASKE_BIT-1:0] vb_maske_i;
   logic [VERI_BIT-1:0]  vb_veri_o;
   logic                 vb_gecerli_o;
   // status
   logic                 hata_o;
   logic                 mesgul_o;
   // memory port
   logic                 bellek_istek_o;
   logic                 bellek_yaz_o;
   logic [ADRES_BIT-1:0] bellek_adres_o;
   logic [VERI_BIT-1:0]  bellek_veri_o;
   logic [MASKE_BIT-1:0] bellek_maske_o;
   logic [VERI_BIT-1:0]  bellek_veri_i;
   logic                 bellek_hazir_i;

   modport slave (
      input  bb_istek_i, bb_adres_i,
      input  vb_istek_i, vb_yaz_i, vb_adres_i, vb_veri_i, vb_maske_i,
      input  bellek_veri_i, bellek_hazir_i,
      output bb_veri_o, bb_gecerli_o, vb_veri_o, vb_gecerli_o,
      output hata_o, mesgul_o,
      output bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o,
      output bellek_maske_o
   );

   modport master (
      output bb_istek_i, bb_adres_i,
      output vb_istek_i, vb_yaz_i, vb_adres_i, vb_veri_i, vb_maske_i,
      output bellek_veri_i, bellek_hazir_i,
      input  bb_veri_o, bb_gecerli_o, vb_veri_o, vb_gecerli_o,
      input  hata_o, mesgul_o,
      input  bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o,
      input  bellek_maske_o
   );
endinterface

// File: rtl/bellek_hakemi.sv
// bellek_hakemi
// Two-way round-robin arbiter. The instruction-fetch port (bb) and the
// load/store port (vb) share the single main-memory port. Only one
// transaction is outstanding at a time. The request is presented to memory
// from registers. Completion is reported with a one-cycle valid pulse on the
// owner's port. A transaction that memory never acknowledges is aborted after
// ZAMAN_ASIMI request cycles and is flagged with hata_o.
// Ports:
//   clk_i, rst_i : clock and asynchronous active-high reset
//   bus          : bellek_hakemi_if.slave (request ports, status, memory port)
//
// state | meaning
// ------+---------------------------------------------------------------
// BOSTA | idle; arbitrates pending requests, memory reply ignored
// ISTEK | bellek_istek_o high; waits for bellek_hazir_i or the timeout
// YANIT | one-cycle gecerli/hata pulse to the owner, then back to BOSTA
module bellek_hakemi #(
   parameter int ADRES_BIT   = 32,
   parameter int VERI_BIT    = 32,
   parameter int ZAMAN_ASIMI = 255
) (
   input logic            clk_i,
   input logic            rst_i,
   bellek_hakemi_if.slave bus
);
   localparam int MASKE_BIT = VERI_BIT / 8;
   localparam int SAYAC_BIT = (ZAMAN_ASIMI < 2) ? 1 : $clog2(ZAMAN_ASIMI + 1);
   localparam logic [SAYAC_BIT-1:0] SAYAC_SON = SAYAC_BIT'(ZAMAN_ASIMI - 1);

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      ISTEK = 2'd1,
      YANIT = 2'd2
   } durum_t;

   durum_t               durum_q, durum_d;
   logic                 son_veri_q, son_veri_d;     // 1: last grant went to data
   logic                 sahip_veri_q, sahip_veri_d; // owner of the active transaction
   logic [SAYAC_BIT-1:0] sayac_q, sayac_d;
   logic                 bellek_istek_q, bellek_istek_d;
   logic                 bellek_yaz_q, bellek_yaz_d;
   logic [ADRES_BIT-1:0] bellek_adres_q, bellek_adres_d;
   logic [VERI_BIT-1:0]  bellek_veri_q, bellek_veri_d;
   logic [MASKE_BIT-1:0] bellek_maske_q, bellek_maske_d;
   logic [VERI_BIT-1:0]  bb_veri_q, bb_veri_d;
   logic [VERI_BIT-1:0]  vb_veri_q, vb_veri_d;
   logic                 bb_gecerli_q, bb_gecerli_d;
   logic                 vb_gecerli_q, vb_gecerli_d;
   logic                 hata_q, hata_d;
   logic                 mesgul_q, mesgul_d;

   logic                 vb_kazan;
   logic                 istek_var;
   logic                 zaman_doldu;

   // Data wins when it asks alone, or on a tie when instruction had the last grant.
   assign vb_kazan    = bus.vb_istek_i & (~bus.bb_istek_i | ~son_veri_q);
   assign istek_var   = bus.bb_istek_i | bus.vb_istek_i;
   assign zaman_doldu = (sayac_q == SAYAC_SON);

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         durum_q        <= BOSTA;
         son_veri_q     <= 1'b0;
         sahip_veri_q   <= 1'b0;
         sayac_q        <= '0;
         bellek_istek_q <= 1'b0;
         bellek_yaz_q   <= 1'b0;
         bellek_adres_q <= '0;
         bellek_veri_q  <= '0;
         bellek_maske_q <= '0;
         bb_veri_q      <= '0;
         vb_veri_q      <= '0;
         bb_gecerli_q   <= 1'b0;
         vb_gecerli_q   <= 1'b0;
         hata_q         <= 1'b0;
         mesgul_q       <= 1'b0;
      end else begin
         durum_q        <= durum_d;
         son_veri_q     <= son_veri_d;
         sahip_veri_q   <= sahip_veri_d;
         sayac_q        <= sayac_d;
         bellek_istek_q <= bellek_istek_d;
         bellek_yaz_q   <= bellek_yaz_d;
         bellek_adres_q <= bellek_adres_d;
         bellek_veri_q  <= bellek_veri_d;
         bellek_maske_q <= bellek_maske_d;
         bb_veri_q      <= bb_veri_d;
         vb_veri_q      <= vb_veri_d;
         bb_gecerli_q   <= bb_gecerli_d;
         vb_gecerli_q   <= vb_gecerli_d;
         hata_q         <= hata_d;
         mesgul_q       <= mesgul_d;
      end
   end

   // next-state logic
   always_comb begin
      durum_d = durum_q;
      case (durum_q)
         BOSTA:   if (istek_var) durum_d = ISTEK;
         ISTEK:   if (bus.bellek_hazir_i || zaman_doldu) durum_d = YANIT;
         YANIT:   durum_d = BOSTA;
         default: durum_d = BOSTA;
      endcase
   end

   // output / datapath logic
   always_comb begin
      son_veri_d     = son_veri_q;
      sahip_veri_d   = sahip_veri_q;
      sayac_d        = sayac_q;
      bellek_istek_d = bellek_istek_q;
      bellek_yaz_d   = bellek_yaz_q;
      bellek_adres_d = bellek_adres_q;
      bellek_veri_d  = bellek_veri_q;
      bellek_maske_d = bellek_maske_q;
      bb_veri_d      = bb_veri_q;
      vb_veri_d      = vb_veri_q;
      bb_gecerli_d   = 1'b0;
      vb_gecerli_d   = 1'b0;
      hata_d         = 1'b0;

      case (durum_q)
         BOSTA: begin
            if (istek_var) begin
               son_veri_d     = vb_kazan;
               sahip_veri_d   = vb_kazan;
               sayac_d        = '0;
               bellek_istek_d = 1'b1;
               if (vb_kazan) begin
                  bellek_yaz_d   = bus.vb_yaz_i;
                  bellek_adres_d = bus.vb_adres_i;
                  bellek_veri_d  = bus.vb_veri_i;
                  bellek_maske_d = bus.vb_maske_i;
               end else begin
                  // instruction fetch is always a plain read
                  bellek_yaz_d   = 1'b0;
                  bellek_adres_d = bus.bb_adres_i;
                  bellek_veri_d  = '0;
                  bellek_maske_d = '0;
               end
            end
         end
         ISTEK: begin
            if (bus.bellek_hazir_i) begin
               // a reply on the limit cycle still counts as a normal completion
               bellek_istek_d = 1'b0;
               if (sahip_veri_q) begin
                  if (!bellek_yaz_q) vb_veri_d = bus.bellek_veri_i;
                  vb_gecerli_d = 1'b1;
               end else begin
                  bb_veri_d    = bus.bellek_veri_i;
                  bb_gecerli_d = 1'b1;
               end
            end else if (zaman_doldu) begin
               bellek_istek_d = 1'b0;
               hata_d         = 1'b1;
               if (sahip_veri_q) vb_gecerli_d = 1'b1;
               else              bb_gecerli_d = 1'b1;
            end else begin
               sayac_d = sayac_q + SAYAC_BIT'(1);
            end
         end
         default: ;
      endcase
   end

   assign mesgul_d = (durum_d != BOSTA);

   assign bus.bellek_istek_o = bellek_istek_q;
   assign bus.bellek_yaz_o   = bellek_yaz_q;
   assign bus.bellek_adres_o = bellek_adres_q;
   assign bus.bellek_veri_o  = bellek_veri_q;
   assign bus.bellek_maske_o = bellek_maske_q;
   assign bus.bb_veri_o      = bb_veri_q;
   assign bus.vb_veri_o      = vb_veri_q;
   assign bus.bb_gecerli_o   = bb_gecerli_q;
   assign bus.vb_gecerli_o   = vb_gecerli_q;
   assign bus.hata_o         = hata_q;
   assign bus.mesgul_o       = mesgul_q;
endmodule

// File: tb/tb_bellek_hakemi.sv
// tb_bellek_hakemi
// Drives bellek_hakemi (ZAMAN_ASIMI = 4) through single reads, round-robin
// ties, a write, a timeout, a reply on the limit cycle, and a mid-transaction
// reset. Each expected completion is queued when its memory reply (or
// timeout) is set up. The queue is drained by a monitor on every valid pulse.
module tb_bellek_hakemi;
   localparam int Z = 4;

   typedef struct packed {
      logic        veri_port;
      logic [31:0] veri;
      logic        hata;
   } beklenen_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   bellek_hakemi_if #(.ADRES_BIT(32), .VERI_BIT(32)) bus ();

   bellek_hakemi #(.ADRES_BIT(32), .VERI_BIT(32), .ZAMAN_ASIMI(Z)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   beklenen_t   sb[$];
   int          sayi_kontrol = 0;
   int          sayi_hata    = 0;
   logic [31:0] bb_son = 32'h0;
   logic [31:0] vb_son = 32'h0;

   task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                          input logic [31:0] beklenen);
      sayi_kontrol++;
      if (gozlenen !== beklenen) begin
         sayi_hata++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", etiket, gozlenen, beklenen, $time);
      end
   endtask

   task automatic sifir_kontrol(input string etiket);
      kontrol({etiket, "_istek"},   32'(bus.bellek_istek_o), 32'h0);
      kontrol({etiket, "_yaz"},     32'(bus.bellek_yaz_o),   32'h0);
      kontrol({etiket, "_adres"},   bus.bellek_adres_o,      32'h0);
      kontrol({etiket, "_bveri"},   bus.bellek_veri_o,       32'h0);
      kontrol({etiket, "_maske"},   32'(bus.bellek_maske_o), 32'h0);
      kontrol({etiket, "_bb_veri"}, bus.bb_veri_o,           32'h0);
      kontrol({etiket, "_vb_veri"}, bus.vb_veri_o,           32'h0);
      kontrol({etiket, "_bb_gec"},  32'(bus.bb_gecerli_o),   32'h0);
      kontrol({etiket, "_vb_gec"},  32'(bus.vb_gecerli_o),   32'h0);
      kontrol({etiket, "_hata"},    32'(bus.hata_o),         32'h0);
      kontrol({etiket, "_mesgul"},  32'(bus.mesgul_o),       32'h0);
   endtask

   // completion monitor
   always @(negedge clk_i) begin
      beklenen_t e;
      if (bus.bb_gecerli_o || bus.vb_gecerli_o) begin
         kontrol("tek_gecerli", 32'(bus.bb_gecerli_o & bus.vb_gecerli_o), 32'h0);
         if (sb.size() == 0) begin
            kontrol("beklenmeyen_gecerli", 32'({bus.bb_gecerli_o, bus.vb_gecerli_o}), 32'h0);
         end else begin
            e = sb.pop_front();
            kontrol("gecerli_port", 32'(bus.vb_gecerli_o), 32'(e.veri_port));
            kontrol("gecerli_veri", e.veri_port ? bus.vb_veri_o : bus.bb_veri_o, e.veri);
            kontrol("gecerli_hata", 32'(bus.hata_o), 32'(e.hata));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic        exp_port;
      logic [31:0] exp_adres, d;

      bus.bb_istek_i = 0; bus.bb_adres_i = 0;
      bus.vb_istek_i = 0; bus.vb_yaz_i = 0; bus.vb_adres_i = 0;
      bus.vb_veri_i = 0;  bus.vb_maske_i = 0;
      bus.bellek_veri_i = 0; bus.bellek_hazir_i = 0;

      repeat (2) @(negedge clk_i);
      sifir_kontrol("reset");
      rst_i = 1'b0;

      // T1: single instruction read, memory answers in cycle 3
      bus.bb_istek_i = 1; bus.bb_adres_i = 32'h100;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_i);
         kontrol("t1_istek", 32'(bus.bellek_istek_o), 32'h1);
         kontrol("t1_adres", bus.bellek_adres_o, 32'h100);
         kontrol("t1_erken_gec", 32'(bus.bb_gecerli_o), 32'h0);
         if (c == 3) begin
            bus.bellek_hazir_i = 1; bus.bellek_veri_i = 32'hDEADBEEF;
            sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
            bb_son = 32'hDEADBEEF;
         end
      end
      @(negedge clk_i);
      bus.bellek_hazir_i = 0;
      kontrol("t1_gecerli", 32'(bus.bb_gecerli_o), 32'h1);
      kontrol("t1_istek_dustu", 32'(bus.bellek_istek_o), 32'h0);
      bus.bb_istek_i = 0;
      @(negedge clk_i);
      kontrol("t1_tek_vurus", 32'(bus.bb_gecerli_o), 32'h0);
      kontrol("t1_mesgul", 32'(bus.mesgul_o), 32'h0);

      // T2: both ports request continuously; expected order data, instr, data, instr
      bus.bb_istek_i = 1; bus.bb_adres_i = 32'h40;
      bus.vb_istek_i = 1; bus.vb_adres_i = 32'h80; bus.vb_yaz_i = 0;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(negedge clk_i);
         bus.bellek_hazir_i = 0;
         if (bus.bellek_istek_o) begin
            exp_port  = (n % 2 == 0);
            exp_adres = exp_port ? 32'h80 : 32'h40;
            kontrol("t2_sira_adres", bus.bellek_adres_o, exp_adres);
            d = 32'hA000_0000 + 32'(n);
            bus.bellek_hazir_i = 1; bus.bellek_veri_i = d;
            sb.push_back('{exp_port, d, 1'b0});
            if (exp_port) vb_son = d; else bb_son = d;
            if (n == 3) begin bus.bb_istek_i = 0; bus.vb_istek_i = 0; end
            n++;
         end
      end
      kontrol("t2_dort_islem", 32'(n), 32'd4);
      bus.bb_istek_i = 0; bus.vb_istek_i = 0;
      @(negedge clk_i); bus.bellek_hazir_i = 0;
      @(negedge clk_i);

      // T3: data write; read data register must keep its previous value
      bus.vb_istek_i = 1; bus.vb_yaz_i = 1; bus.vb_adres_i = 32'h2000;
      bus.vb_veri_i = 32'h12345678; bus.vb_maske_i = 4'b0011;
      @(negedge clk_i);
      kontrol("t3_istek", 32'(bus.bellek_istek_o), 32'h1);
      kontrol("t3_yaz",   32'(bus.bellek_yaz_o), 32'h1);
      kontrol("t3_adres", bus.bellek_adres_o, 32'h2000);
      kontrol("t3_veri",  bus.bellek_veri_o, 32'h12345678);
      kontrol("t3_maske", 32'(bus.bellek_maske_o), 32'h3);
      bus.bellek_hazir_i = 1; bus.bellek_veri_i = 32'hFFFFFFFF;
      sb.push_back('{1'b1, vb_son, 1'b0});
      @(negedge clk_i);
      bus.bellek_hazir_i = 0;
      kontrol("t3_gecerli", 32'(bus.vb_gecerli_o), 32'h1);
      bus.vb_istek_i = 0; bus.vb_yaz_i = 0;
      @(negedge clk_i);

      // T4: timeout; inputs disturbed while ISTEK must not matter
      bus.bb_istek_i = 1; bus.bb_adres_i = 32'h300;
      for (int c = 1; c <= Z; c++) begin
         @(negedge clk_i);
         kontrol("t4_istek", 32'(bus.bellek_istek_o), 32'h1);
         kontrol("t4_adres", bus.bellek_adres_o, 32'h300);
         if (c == 2) begin bus.bb_adres_i = 32'hBEEF; bus.vb_istek_i = 1; end
         if (c == 3) bus.vb_istek_i = 0;
         if (c == Z) sb.push_back('{1'b0, bb_son, 1'b1});
      end
      @(negedge clk_i);
      kontrol("t4_gecerli", 32'(bus.bb_gecerli_o), 32'h1);
      kontrol("t4_hata", 32'(bus.hata_o), 32'h1);
      kontrol("t4_istek_dustu", 32'(bus.bellek_istek_o), 32'h0);
      bus.bb_istek_i = 0;
      @(negedge clk_i);
      kontrol("t4_mesgul", 32'(bus.mesgul_o), 32'h0);
      kontrol("t4_hata_temiz", 32'(bus.hata_o), 32'h0);

      // T5: reply on the limit cycle is a normal completion
      bus.bb_istek_i = 1; bus.bb_adres_i = 32'h400;
      for (int c = 1; c <= Z; c++) begin
         @(negedge clk_i);
         kontrol("t5_istek", 32'(bus.bellek_istek_o), 32'h1);
         if (c == Z) begin
            bus.bellek_hazir_i = 1; bus.bellek_veri_i = 32'h5555AAAA;
            sb.push_back('{1'b0, 32'h5555AAAA, 1'b0});
            bb_son = 32'h5555AAAA;
         end
      end
      @(negedge clk_i);
      bus.bellek_hazir_i = 0;
      kontrol("t5_gecerli", 32'(bus.bb_gecerli_o), 32'h1);
      kontrol("t5_hata", 32'(bus.hata_o), 32'h0);
      bus.bb_istek_i = 0;
      @(negedge clk_i);

      // T6: reset in the middle of a data read, then a late memory reply
      bus.vb_istek_i = 1; bus.vb_adres_i = 32'h600; bus.vb_yaz_i = 0;
      @(negedge clk_i);
      kontrol("t6_istek", 32'(bus.bellek_istek_o), 32'h1);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      sifir_kontrol("t6_reset");
      bus.vb_istek_i = 0;
      bb_son = 32'h0; vb_son = 32'h0;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      bus.bellek_hazir_i = 1; bus.bellek_veri_i = 32'h77777777;
      @(negedge clk_i);
      bus.bellek_hazir_i = 0;
      kontrol("t6_gec_hazir_istek", 32'(bus.bellek_istek_o), 32'h0);
      kontrol("t6_gec_hazir_mesgul", 32'(bus.mesgul_o), 32'h0);
      kontrol("t6_vb_veri", bus.vb_veri_o, 32'h0);

      // fresh tie after reset: data must win
      bus.bb_istek_i = 1; bus.bb_adres_i = 32'h700;
      bus.vb_istek_i = 1; bus.vb_adres_i = 32'h800;
      @(negedge clk_i);
      kontrol("t6_esitlik_adres", bus.bellek_adres_o, 32'h800);
      bus.bellek_hazir_i = 1; bus.bellek_veri_i = 32'h13579BDF;
      sb.push_back('{1'b1, 32'h13579BDF, 1'b0});
      bus.bb_istek_i = 0; bus.vb_istek_i = 0;
      @(negedge clk_i);
      bus.bellek_hazir_i = 0;
      kontrol("t6_gecerli", 32'(bus.vb_gecerli_o), 32'h1);
      repeat (2) @(negedge clk_i);
      kontrol("kuyruk_bos", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", sayi_kontrol, sayi_hata);
      $finish;
   end
endmodule
